// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a melody stored in an external synchronous ROM.
// Each ROM entry holds {half_period, duration_ticks}. The block fetches an entry,
// plays a square wave with that half-period for duration*TICK_DIV cycles, and
// then moves on to the next entry. A duration of 0 marks the end of the song.
// startPlaying (re)starts the song and key1 stops it.
// Both inputs are asynchronous levels and are synchronized internally.
module melody_sequencer #(
    parameter int TICK_DIV  = 1200000,
    parameter int IDX_W     = 4,
    parameter int NUM_NOTES = 16,
    parameter int HALF_W    = 16,
    parameter int LOOP      = 0
) (
    input  logic              clk12MHz,
    input  logic              reset,
    input  logic              startPlaying,
    input  logic              key1,
    output logic [IDX_W-1:0]  rom_addr,
    input  logic [HALF_W+7:0] rom_data,
    output logic              note,
    output logic              playing,
    output logic              debug
);

    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  LAST_ADDR = IDX_W'(NUM_NOTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        PLAY  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Bit 0 and bit 1 are the two synchronizer flops, bit 2 is the edge register.
    logic [2:0] start_sync;
    logic [2:0] key_sync;
    logic       start_edge;
    logic       stop_edge;

    logic [HALF_W-1:0] half_reg;
    logic [7:0]        dur_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [HALF_W-1:0] tone_cnt;

    logic [IDX_W-1:0]  addr_next;
    logic [HALF_W-1:0] half_next;
    logic [7:0]        dur_next;
    logic [TICK_W-1:0] tick_next;
    logic [HALF_W-1:0] tone_next;
    logic              note_next;
    logic              debug_next;

    logic [HALF_W-1:0] rom_half;
    logic [7:0]        rom_dur;

    assign rom_half   = rom_data[HALF_W+7:8];
    assign rom_dur    = rom_data[7:0];
    assign start_edge = start_sync[1] & ~start_sync[2];
    assign stop_edge  = key_sync[1] & ~key_sync[2];
    assign playing    = (state != IDLE);

    // Bring the button levels into the clock domain and keep one extra flop for edge detection.
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            start_sync <= 3'b000;
            key_sync   <= 3'b000;
        end else begin
            start_sync <= {start_sync[1:0], startPlaying};
            key_sync   <= {key_sync[1:0], key1};
        end
    end

    // State register.
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and datapath updates; stop beats start, and start restarts from any state.
    always_comb begin
        state_next = state;
        addr_next  = rom_addr;
        half_next  = half_reg;
        dur_next   = dur_cnt;
        tick_next  = tick_cnt;
        tone_next  = tone_cnt;
        note_next  = note;
        debug_next = debug;

        if (stop_edge) begin
            if (state != IDLE) begin
                state_next = IDLE;
                addr_next  = '0;
                note_next  = 1'b0;
                tick_next  = '0;
                tone_next  = '0;
            end
        end else if (start_edge) begin
            state_next = FETCH;
            addr_next  = '0;
            note_next  = 1'b0;
            tick_next  = '0;
            tone_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    note_next = 1'b0;
                end

                FETCH: begin
                    state_next = LOAD;
                end

                LOAD: begin
                    if (rom_dur == 8'd0) begin
                        if (LOOP != 0) begin
                            addr_next  = '0;
                            state_next = FETCH;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        half_next  = rom_half;
                        dur_next   = rom_dur;
                        tick_next  = '0;
                        tone_next  = '0;
                        note_next  = 1'b0;
                        debug_next = ~debug;
                        state_next = PLAY;
                    end
                end

                PLAY: begin
                    if (half_reg == '0) begin
                        note_next = 1'b0;
                    end else if (tone_cnt == (half_reg - HALF_W'(1))) begin
                        note_next = ~note;
                        tone_next = '0;
                    end else begin
                        tone_next = tone_cnt + HALF_W'(1);
                    end

                    if (tick_cnt == TICK_LAST) begin
                        tick_next = '0;
                        if (dur_cnt <= 8'd1) begin
                            dur_next  = 8'd0;
                            note_next = 1'b0;
                            tone_next = '0;
                            if (rom_addr >= LAST_ADDR) begin
                                if (LOOP != 0) begin
                                    addr_next  = '0;
                                    state_next = FETCH;
                                end else begin
                                    state_next = IDLE;
                                end
                            end else begin
                                addr_next  = rom_addr + IDX_W'(1);
                                state_next = FETCH;
                            end
                        end else begin
                            dur_next = dur_cnt - 8'd1;
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Datapath registers: address, latched note entry, counters and outputs.
    always_ff @(posedge clk12MHz) begin
        if (reset) begin
            rom_addr <= '0;
            half_reg <= '0;
            dur_cnt  <= 8'd0;
            tick_cnt <= '0;
            tone_cnt <= '0;
            note     <= 1'b0;
            debug    <= 1'b0;
        end else begin
            rom_addr <= addr_next;
            half_reg <= half_next;
            dur_cnt  <= dur_next;
            tick_cnt <= tick_next;
            tone_cnt <= tone_next;
            note     <= note_next;
            debug    <= debug_next;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed bench for melody_sequencer with a short tick (10 cycles)
// and a 4-entry note table. A second instance built with LOOP=1 shares the ROM contents.
module tb_melody_sequencer;

    localparam int TICK_DIV  = 10;
    localparam int IDX_W     = 4;
    localparam int NUM_NOTES = 4;
    localparam int HALF_W    = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              startPlaying;
    logic              key1;
    logic              start_loop;
    logic              key_loop;
    logic [IDX_W-1:0]  rom_addr;
    logic [IDX_W-1:0]  rom_addr_l;
    logic [HALF_W+7:0] rom_data;
    logic [HALF_W+7:0] rom_data_l;
    logic              note;
    logic              note_l;
    logic              playing;
    logic              playing_l;
    logic              debug;
    logic              debug_l;

    logic [HALF_W+7:0] rom [0:3];

    int   checks   = 0;
    int   failures = 0;
    int   play_cnt;
    int   play_cnt_l;
    int   note_hi;
    int   rest_hi;
    int   first_play;
    int   first_note;
    int   dbg_tog;
    logic prev_dbg;

    melody_sequencer #(
        .TICK_DIV (TICK_DIV),
        .IDX_W    (IDX_W),
        .NUM_NOTES(NUM_NOTES),
        .HALF_W   (HALF_W),
        .LOOP     (0)
    ) dut (
        .clk12MHz    (clk),
        .reset       (reset),
        .startPlaying(startPlaying),
        .key1        (key1),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .note        (note),
        .playing     (playing),
        .debug       (debug)
    );

    melody_sequencer #(
        .TICK_DIV (TICK_DIV),
        .IDX_W    (IDX_W),
        .NUM_NOTES(NUM_NOTES),
        .HALF_W   (HALF_W),
        .LOOP     (1)
    ) dut_loop (
        .clk12MHz    (clk),
        .reset       (reset),
        .startPlaying(start_loop),
        .key1        (key_loop),
        .rom_addr    (rom_addr_l),
        .rom_data    (rom_data_l),
        .note        (note_l),
        .playing     (playing_l),
        .debug       (debug_l)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Synchronous ROM model: data appears one cycle after the address.
    always @(posedge clk) begin
        rom_data   <= rom[rom_addr[1:0]];
        rom_data_l <= rom[rom_addr_l[1:0]];
    end

    task automatic stepClock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic start, input logic key, input logic rst);
        startPlaying = start;
        key1         = key;
        reset        = rst;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadRom(input logic [23:0] a0, input logic [23:0] a1,
                           input logic [23:0] a2, input logic [23:0] a3);
        rom[0] = a0;
        rom[1] = a1;
        rom[2] = a2;
        rom[3] = a3;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b1);
        start_loop = 1'b0;
        key_loop   = 1'b0;
        repeat (5) stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        start_loop = 1'b0;
        key_loop   = 1'b0;
        loadRom({16'd3, 8'd2}, {16'd0, 8'd1}, {16'd0, 8'd0}, {16'd0, 8'd0});
        @(negedge clk);

        $display("[TB] reset and idle stability");
        doReset();
        checkOutput("t1_reset", 32'({note, playing, debug, rom_addr}), 32'd0);
        for (int i = 0; i < 20; i++) begin
            stepClock();
            checkOutput("t1_idle_stable", 32'({note, playing, debug, rom_addr}), 32'd0);
        end

        $display("[TB] basic song");
        applyStimulus(1'b1, 1'b0, 1'b0);
        play_cnt   = 0;
        note_hi    = 0;
        rest_hi    = 0;
        first_play = -1;
        first_note = -1;
        dbg_tog    = 0;
        prev_dbg   = 1'b0;
        for (int i = 0; i < 44; i++) begin
            stepClock();
            if (playing === 1'b1) begin
                play_cnt++;
                if (first_play < 0) first_play = i;
            end
            if (note === 1'b1) begin
                note_hi++;
                if (first_note < 0) first_note = i;
                if (i >= 26 && i <= 35) rest_hi++;
            end
            if (debug !== prev_dbg) dbg_tog++;
            prev_dbg = debug;
            if (i >= 4 && i <= 23) begin
                checkOutput("t2_note_wave", 32'(note), 32'(((i - 4) / 3) % 2));
            end
        end
        checkOutput("t2_playing_cycles", 32'(play_cnt), 32'd36);
        checkOutput("t2_first_playing", 32'(first_play), 32'd2);
        checkOutput("t2_first_note_high", 32'(first_note), 32'd7);
        checkOutput("t2_note_high_cycles", 32'(note_hi), 32'd9);
        checkOutput("t2_rest_silent", 32'(rest_hi), 32'd0);
        checkOutput("t2_debug_toggles", 32'(dbg_tog), 32'd2);
        checkOutput("t2_end_addr", 32'(rom_addr), 32'd2);
        checkOutput("t2_end_idle", 32'(playing), 32'd0);

        $display("[TB] stop mid-note and replay");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            stepClock();
            if (i == 1) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("t3_in_play", 32'(playing), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepClock();
        stepClock();
        checkOutput("t3_stop_not_yet", 32'(playing), 32'd1);
        stepClock();
        checkOutput("t3_stopped", 32'({note, playing, rom_addr}), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) stepClock();
        checkOutput("t3_stays_idle", 32'(playing), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            stepClock();
            if (i == 1) applyStimulus(1'b0, 1'b0, 1'b0);
            if (i == 2) checkOutput("t3_replay_addr", 32'({playing, rom_addr}), 32'({1'b1, 4'd0}));
            if (i == 3) checkOutput("t3_replay_dbg_before", 32'(debug), 32'd1);
            if (i == 4) checkOutput("t3_replay_dbg_after", 32'(debug), 32'd0);
            if (i == 6) checkOutput("t3_replay_note_low", 32'(note), 32'd0);
            if (i == 7) checkOutput("t3_replay_note_high", 32'(note), 32'd1);
        end
        checkOutput("t3_replay_end", 32'({playing, rom_addr}), 32'({1'b0, 4'd2}));

        $display("[TB] table end, with and without loop");
        loadRom({16'd2, 8'd1}, {16'd2, 8'd1}, {16'd2, 8'd1}, {16'd2, 8'd1});
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        start_loop = 1'b1;
        play_cnt   = 0;
        play_cnt_l = 0;
        note_hi    = 0;
        for (int i = 0; i < 56; i++) begin
            stepClock();
            if (i == 1) begin
                applyStimulus(1'b0, 1'b0, 1'b0);
                start_loop = 1'b0;
            end
            if (playing === 1'b1) play_cnt++;
            if (playing_l === 1'b1) play_cnt_l++;
            if (note === 1'b1) note_hi++;
            if (i >= 4 && i <= 13) begin
                checkOutput("t4_note_wave", 32'(note), 32'(((i - 4) / 2) % 2));
            end
            if (i == 49) begin
                checkOutput("t4_last_note", 32'({playing, rom_addr}), 32'({1'b1, 4'd3}));
                checkOutput("t4l_last_note", 32'({playing_l, rom_addr_l}), 32'({1'b1, 4'd3}));
            end
            if (i == 50) begin
                checkOutput("t4_idle_after_a3", 32'({playing, rom_addr}), 32'({1'b0, 4'd3}));
                checkOutput("t4l_fetch_a0", 32'({playing_l, rom_addr_l}), 32'({1'b1, 4'd0}));
            end
            if (i == 51) checkOutput("t4l_dbg_before_reload", 32'(debug_l), 32'd0);
            if (i == 52) checkOutput("t4l_dbg_after_reload", 32'(debug_l), 32'd1);
        end
        checkOutput("t4_playing_cycles", 32'(play_cnt), 32'd48);
        checkOutput("t4_note_high_cycles", 32'(note_hi), 32'd16);
        checkOutput("t4_end_addr", 32'(rom_addr), 32'd3);
        checkOutput("t4l_playing_cycles", 32'(play_cnt_l), 32'd54);
        key_loop = 1'b1;
        repeat (3) stepClock();
        key_loop = 1'b0;
        checkOutput("t4l_stopped", 32'({note_l, playing_l, rom_addr_l}), 32'd0);

        $display("[TB] simultaneous edges and restart");
        loadRom({16'd3, 8'd2}, {16'd0, 8'd1}, {16'd0, 8'd0}, {16'd0, 8'd0});
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            stepClock();
            if (i == 1) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        stepClock();
        stepClock();
        checkOutput("t5_both_not_yet", 32'(playing), 32'd1);
        stepClock();
        checkOutput("t5_both_idle", 32'({note, playing, rom_addr}), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) stepClock();
        checkOutput("t5_stop_wins", 32'(playing), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            stepClock();
            if (i == 1) applyStimulus(1'b0, 1'b0, 1'b0);
            if (i == 27) checkOutput("t5_in_rest", 32'({playing, note, rom_addr}), 32'({1'b1, 1'b0, 4'd1}));
            if (i == 28) applyStimulus(1'b1, 1'b0, 1'b0);
            if (i == 30) begin
                checkOutput("t5_before_restart", 32'({debug, rom_addr}), 32'({1'b1, 4'd1}));
                applyStimulus(1'b0, 1'b0, 1'b0);
            end
            if (i == 31) checkOutput("t5_restart_addr", 32'({playing, note, rom_addr}), 32'({1'b1, 1'b0, 4'd0}));
            if (i == 32) checkOutput("t5_restart_load", 32'(debug), 32'd1);
            if (i == 33) checkOutput("t5_restart_dbg", 32'(debug), 32'd0);
            if (i == 35) checkOutput("t5_restart_note_low", 32'(note), 32'd0);
            if (i == 36) checkOutput("t5_restart_note_high", 32'(note), 32'd1);
        end

        $display("[TB] reset during a note");
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            stepClock();
            if (i == 1) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("t6_note_high", 32'({playing, note}), 32'({1'b1, 1'b1}));
        applyStimulus(1'b0, 1'b0, 1'b1);
        stepClock();
        checkOutput("t6_reset_outputs", 32'({note, playing, debug, rom_addr}), 32'd0);
        checkOutput("t6_reset_tick", 32'(dut.tick_cnt), 32'd0);
        checkOutput("t6_reset_tone", 32'(dut.tone_cnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) stepClock();
        checkOutput("t6_idle_after", 32'({note, playing, rom_addr}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Sequences the tone generator path: steps through a note table in an external synchronous ROM and produces the square-wave `note` output.
- Each table entry holds a half-period and a duration in ticks.
- `startPlaying` starts playback and `key1` stops it.
- Sits between the board buttons and the speaker pin, and replaces free-running tone logic with a scheduled melody.

Parameters:
- TICK_DIV, 1200000: clk12MHz cycles per duration tick (100 ms at 12 MHz).
- IDX_W, 4: ROM address width.
- NUM_NOTES, 16: table length. Last valid address is NUM_NOTES-1.
- HALF_W, 16: half-period field width.
- LOOP, 0: 1 = restart at address 0 after the table ends, 0 = return to IDLE.

Ports:
- clk12MHz  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- startPlaying  in  1  asynchronous level. A rising edge (re)starts playback from address 0.
- key1  in  1  asynchronous button level. A rising edge stops playback.
- rom_addr  out  IDX_W  note-table address.
- rom_data  in  HALF_W+8  [HALF_W+7:8] is the half-period in cycles (0 = rest); [7:0] is the duration in ticks (0 = end marker). Valid one cycle after rom_addr changes.
- note  out  1  square-wave output to the speaker.
- playing  out  1  high while state != IDLE (decoded from the state register).
- debug  out  1  toggles on every note load.

Behaviour:
- Reset: state=IDLE, rom_addr=0, note=0, playing=0, debug=0, all counters and synchronizer flops 0. Reset overrides everything, including mid-note.
- Input conditioning:
  - startPlaying and key1 each pass through 2 flops, then an edge register; edge = sync2 & ~sync3.
  - The action occurs at the 2nd clock edge after the edge at which the input is first sampled high.
  - Pulses shorter than 1 cycle may be missed.
- State machine: IDLE, FETCH, LOAD, PLAY.
  - IDLE: note=0. On a start edge: rom_addr<=0, go to FETCH.
  - FETCH: 1 cycle for ROM latency, then go to LOAD.
  - LOAD, when rom_data duration==0: end of song. If LOOP=1, rom_addr<=0 and go to FETCH; else go to IDLE.
  - LOAD, otherwise: latch half-period and duration; tick_cnt=0, tone_cnt=0, note=0; toggle debug; go to PLAY.
  - PLAY: tick_cnt counts 0..TICK_DIV-1 and wraps. Each wrap decrements the duration counter. PLAY lasts exactly duration*TICK_DIV cycles.
  - PLAY exit, on the wrap that exhausts the duration:
    - Force note=0.
    - If rom_addr==NUM_NOTES-1: with LOOP=1, set rom_addr<=0 and go to FETCH; with LOOP=0, go to IDLE.
    - Otherwise, rom_addr<=rom_addr+1 and go to FETCH.
- Tone generation, PLAY state only:
  - If half-period==0 (rest), note holds 0.
  - Otherwise tone_cnt increments each cycle. When tone_cnt==half-1, note toggles and tone_cnt<=0.
  - Output period = 2*half cycles. The first toggle happens on the half-th PLAY cycle.
- Stop edge (key1), any state except IDLE: next state IDLE, note=0, rom_addr=0. In IDLE it is ignored.
- Start edge in FETCH/LOAD/PLAY: restart, i.e. rom_addr<=0 and go to FETCH.
- Start and stop edges in the same cycle: stop wins.
- rom_addr never exceeds NUM_NOTES-1. There is no wrap through arithmetic overflow.

Test Plan:
(Parameters for all scenarios: TICK_DIV=10, NUM_NOTES=4, LOOP=0. ROM contents: a0={3,2}, a1={0,1}, a2={x,0}.)
1. Reset held 5 cycles, then released -> note=0, playing=0, rom_addr=0, debug=0. All outputs are stable for 20 cycles with no input activity.
2. Basic song: startPlaying rises and holds -> playing high for exactly 36 cycles.
   - Note toggles every 3 cycles during the 20-cycle first PLAY.
   - Note stays 0 for the 10-cycle rest.
   - debug toggles twice.
   - Ends in IDLE with rom_addr=2.
3. Stop mid-note: key1 edge 8 cycles into the first PLAY -> within 3 cycles, playing=0, note=0, rom_addr=0. A later start edge replays from a0.
4. Table end: ROM a0..a3 all {2,1} -> four 10-cycle notes with period 4. After a3 the state goes to IDLE without wrapping; rom_addr stays 3. Rerun with LOOP=1 -> FETCH at a0 follows a3 with no IDLE cycle.
5. Simultaneous start and stop edges during PLAY -> IDLE, playing=0. Start edge alone during PLAY -> restart at rom_addr=0 and debug toggles.
6. Reset asserted mid-PLAY with note=1 -> next cycle note=0, state IDLE, tone and tick counters 0.
